inverse_clarke_seq: RTL and testbench
=====================================

// Module: inverse_clarke_seq
// PURPOSE
// - Inverse Clarke transform: stationary-frame alpha/beta (Q15) -> three-phase a/b/c (Q15).
// - Output side of the FOC current/voltage path; feeds the PWM/SVM modulator stage.
// - One shared multiplier, ready/valid handshake on input and output, one transform in flight.
// PARAMETERS
// - DATA_W   16     width of all signed Q(DATA_W-1) data ports
// - K_S3_2   28378  round(sqrt(3)/2 * 2^(DATA_W-1)), unsigned constant
// PORTS
// - clk        in   1       system clock, all logic on rising edge
// - rst        in   1       synchronous reset, active-high
// - in_valid   in   1       alpha/beta valid
// - in_ready   out  1       block can accept a sample
// - v_alpha    in   DATA_W  signed Q15 alpha
// - v_beta     in   DATA_W  signed Q15 beta
// - out_valid  out  1       v_a/v_b/v_c valid
// - out_ready  in   1       downstream accepts outputs
// - v_a        out  DATA_W  signed Q15 phase A
// - v_b        out  DATA_W  signed Q15 phase B
// - v_c        out  DATA_W  signed Q15 phase C
// - sat_flag   out  1       at least one output clamped in current result
// BEHAVIOUR
// - One clock; reset is synchronous and active-high; clk and rst as named above.
// - Reset: state=IDLE, in_ready=1, out_valid=0, v_a=v_b=v_c=0, sat_flag=0; in-flight sample dropped.
// - FSM: IDLE -> MUL -> SUM -> HOLD -> IDLE.
//   - IDLE: in_ready=1; in_valid=1 at edge k latches alpha, beta; go MUL.
//   - MUL: p = beta*K_S3_2 (2*DATA_W signed), registered; go SUM.
//   - SUM: outputs computed and registered; out_valid=1 after edge k+2; go HOLD.
//   - HOLD: outputs held stable; out_valid & out_ready -> out_valid=0 and IDLE next edge.
// - in_ready=1 only in IDLE; throughput 1 sample per 4 cycles with out_ready held high.
// - out_ready ignored when out_valid=0; in_valid ignored outside IDLE, not queued.
// - Arithmetic, DATA_W+2 bit signed intermediates:
//   - h = alpha >>> 1 (arithmetic, floor)
//   - k = (p + 2^(DATA_W-2)) >>> (DATA_W-1) (round half up)
//   - a = alpha; b = -h + k; c = -h - k
// - v_a never overflows; only b and c can exceed the range.
// - Outputs change only on the SUM edge; they stay stable through HOLD and idle.
// - rst asserted in any state overrides all other activity that edge.
// CONFIGURATION
// - INV_CLARKE_SAT_EN defined:
//   - b, c clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   - sat_flag=1 with the result if either clamped; cleared when the next result registers.
// - Not defined:
//   - b, c take the low DATA_W bits (two's-complement wrap).
//   - sat_flag tied 0.
// TESTING
// - Reset, then alpha=16384, beta=0, out_ready=1 -> a=16384, b=-8192, c=-8192; out_valid 2 edges after accept.
// - alpha=0, beta=32767 -> a=0, b=28377, c=-28377, sat_flag=0.
// - alpha=-32768, beta=32767, SAT_EN -> a=-32768, b=32767, c=-11993, sat_flag=1.
//   - Same input, no SAT_EN -> b=-20775, c=-11993, sat_flag=0.
// - out_ready=0 for 10 cycles -> outputs and out_valid held, in_ready=0, in_valid pulses ignored.
//   - Then out_ready=1 -> exactly one handshake; in_ready=1 next cycle.
// - rst pulsed in MUL and in HOLD -> next cycle all outputs 0, in_ready=1, no stale out_valid.
// - 60 Hz balanced Q15 sweep through forward Clarke then this block -> a,b,c within +/-2 LSB of source.

Source files
------------

// File: rtl/inverse_clarke_seq.sv
// Inverse Clarke transform alpha/beta -> a/b/c (signed Q15), one shared multiply, one sample in flight.
// Latency: out_valid rises 2 edges after accept; in_ready only in IDLE, result held until out_ready.
// Optional: define INV_CLARKE_SAT_EN to clamp b/c and report sat_flag; otherwise b/c wrap and sat_flag=0.
module inverse_clarke_seq #(
  parameter int DATA_W = 16,
  parameter int K_S3_2 = 28378
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] v_alpha,
  input  logic signed [DATA_W-1:0] v_beta,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] v_a,
  output logic signed [DATA_W-1:0] v_b,
  output logic signed [DATA_W-1:0] v_c,
  output logic                     sat_flag
);

  localparam int PW = 2 * DATA_W;
  localparam int IW = DATA_W + 2;

  localparam logic signed [PW-1:0] K_C = PW'(K_S3_2);
  localparam logic signed [PW-1:0] RND =
    {{(PW-DATA_W+1){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};
  localparam logic signed [IW-1:0] MAX_V = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] alpha_q, alpha_d;
  logic signed [DATA_W-1:0] beta_q, beta_d;
  logic signed [PW-1:0]     p_q, p_d;
  logic signed [DATA_W-1:0] va_q, va_d;
  logic signed [DATA_W-1:0] vb_q, vb_d;
  logic signed [DATA_W-1:0] vc_q, vc_d;

  logic signed [PW-1:0]     beta_ext;
  logic signed [IW-1:0]     alpha_ext;
  logic signed [IW-1:0]     h_s;
  logic signed [IW-1:0]     k_s;
  logic signed [IW-1:0]     b_s;
  logic signed [IW-1:0]     c_s;
  logic signed [DATA_W-1:0] b_o;
  logic signed [DATA_W-1:0] c_o;

`ifdef INV_CLARKE_SAT_EN
  logic sat_q, sat_d;
  logic b_hi, b_lo, c_hi, c_lo;
`endif

  // Datapath: intermediates carry two guard bits so b/c overflow is visible before clamp/wrap.
  always_comb begin
    beta_ext  = {{(PW-DATA_W){beta_q[DATA_W-1]}}, beta_q};
    alpha_ext = {{2{alpha_q[DATA_W-1]}}, alpha_q};
    h_s       = alpha_ext >>> 1;
    k_s       = IW'((p_q + RND) >>> (DATA_W-1));
    b_s       = k_s - h_s;
    c_s       = -h_s - k_s;
`ifdef INV_CLARKE_SAT_EN
    b_hi = (b_s > MAX_V);
    b_lo = (b_s < MIN_V);
    c_hi = (c_s > MAX_V);
    c_lo = (c_s < MIN_V);
    b_o  = b_hi ? DATA_W'(MAX_V) : (b_lo ? DATA_W'(MIN_V) : DATA_W'(b_s));
    c_o  = c_hi ? DATA_W'(MAX_V) : (c_lo ? DATA_W'(MIN_V) : DATA_W'(c_s));
`else
    b_o = DATA_W'(b_s);
    c_o = DATA_W'(c_s);
`endif
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    p_d     = p_q;
    va_d    = va_q;
    vb_d    = vb_q;
    vc_d    = vc_q;
`ifdef INV_CLARKE_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alpha_d = v_alpha;
          beta_d  = v_beta;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = beta_ext * K_C;
        state_d = SUM;
      end
      SUM: begin
        va_d    = alpha_q;
        vb_d    = b_o;
        vc_d    = c_o;
`ifdef INV_CLARKE_SAT_EN
        sat_d   = b_hi | b_lo | c_hi | c_lo;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      alpha_q <= '0;
      beta_q  <= '0;
      p_q     <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vc_q    <= '0;
`ifdef INV_CLARKE_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      p_q     <= p_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vc_q    <= vc_d;
`ifdef INV_CLARKE_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign v_a       = va_q;
  assign v_b       = vb_q;
  assign v_c       = vc_q;
`ifdef INV_CLARKE_SAT_EN
  assign sat_flag  = sat_q;
`else
  assign sat_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_inverse_clarke_seq.sv
// Directed bench for inverse_clarke_seq: vector table, backpressure, reset-in-flight and sweep.
module tb_inverse_clarke_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] v_alpha;
  logic signed [15:0] v_beta;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] v_a;
  logic signed [15:0] v_b;
  logic signed [15:0] v_c;
  logic               sat_flag;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  typedef struct {
    int al, be, ea, eb, ec, es;
  } vec_t;

  vec_t vecs[10];

  inverse_clarke_seq #(.DATA_W(16), .K_S3_2(28378)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v_alpha   (v_alpha),
    .v_beta    (v_beta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v_a       (v_a),
    .v_b       (v_b),
    .v_c       (v_c),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
    end
  endtask

  // Returns at the negedge following the accepting posedge.
  task automatic send(input int al, input int be);
    int n;
    @(negedge clk);
    v_alpha  = 16'(al);
    v_beta   = 16'(be);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic setv(input int i, input int al, input int be, input int ea,
                      input int eb, input int ec, input int es);
    vecs[i].al = al; vecs[i].be = be; vecs[i].ea = ea;
    vecs[i].eb = eb; vecs[i].ec = ec; vecs[i].es = es;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_v_a"}, int'(v_a), 0);
    chk({tag, "_v_b"}, int'(v_b), 0);
    chk({tag, "_v_c"}, int'(v_c), 0);
    chk({tag, "_sat"}, int'(sat_flag), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, hs0, seen;
    int ra, rb, rc, sa, sb, sc;
    real th, pi, amp;

    setv(0, 16384, 0, 16384, -8192, -8192, 0);
    setv(1, 0, 32767, 0, 28377, -28377, 0);
`ifdef INV_CLARKE_SAT_EN
    setv(2, -32768, 32767, -32768, 32767, -11993, 1);
    setv(3, 32767, -32768, 32767, -32768, 11995, 1);
`else
    setv(2, -32768, 32767, -32768, -20775, -11993, 0);
    setv(3, 32767, -32768, 32767, 20775, 11995, 0);
`endif
    setv(4, 0, 0, 0, 0, 0, 0);
    setv(5, 1, 0, 1, 0, 0, 0);
    setv(6, -1, 0, -1, 1, 1, 0);
    setv(7, 0, -32768, 0, -28378, 28378, 0);
    setv(8, 100, 200, 100, 123, -223, 0);
    setv(9, -3, -1, -3, 1, 3, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; v_alpha = '0; v_beta = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].al, vecs[i].be);
      wait_out(lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_a", i), int'(v_a), vecs[i].ea);
      chk($sformatf("v%0d_b", i), int'(v_b), vecs[i].eb);
      chk($sformatf("v%0d_c", i), int'(v_c), vecs[i].ec);
      chk($sformatf("v%0d_sat", i), int'(sat_flag), vecs[i].es);
    end

    // Backpressure: result held, new inputs ignored, exactly one handshake on release.
    @(negedge clk);
    out_ready = 1'b0;
    send(16384, 0);
    wait_out(lat);
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_v_a", int'(v_a), 16384);
      chk("bp_v_b", int'(v_b), -8192);
      chk("bp_v_c", int'(v_c), -8192);
      in_valid = (i % 2 == 0);
      v_alpha  = 16'sd1234;
      v_beta   = -16'sd555;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp_no_queued_result", seen, 0);
    chk("bp_handshakes", hs_cnt - hs0, 1);

    // Reset while in MUL.
    send(100, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rst_mul");
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mul_no_stale", seen, 0);

    // Reset while in HOLD.
    out_ready = 1'b0;
    send(100, 200);
    wait_out(lat);
    chk("pre_rst_hold_b", int'(v_b), 123);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check_idle_zero("rst_hold");
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_hold_no_stale", seen, 0);

    // Balanced three-phase sweep through a forward Clarke model.
    pi  = 3.14159265358979;
    amp = 20000.0;
    for (int i = 0; i < 24; i++) begin
      th = 2.0 * pi * real'(i) / 24.0;
      sa = int'(amp * $cos(th));
      sb = int'(amp * $cos(th - 2.0 * pi / 3.0));
      sc = int'(amp * $cos(th + 2.0 * pi / 3.0));
      ra = int'(real'(2 * sa - sb - sc) / 3.0);
      rb = int'(real'(sb - sc) / $sqrt(3.0));
      send(ra, rb);
      wait_out(lat);
      chk_tol($sformatf("sweep%0d_a", i), int'(v_a), sa, 2);
      chk_tol($sformatf("sweep%0d_b", i), int'(v_b), sb, 2);
      chk_tol($sformatf("sweep%0d_c", i), int'(v_c), sc, 2);
      rc = int'(sat_flag);
      chk($sformatf("sweep%0d_sat", i), rc, 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
